// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate clock enable, x/y raster counters and
// registered sync/blank decode. Defaults give 640x480@60 Hz from a 100 MHz clock.
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [9:0] X_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VIS);
    localparam logic [9:0] Y_VIS    = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [3:0] div_r;
    logic       p_tick_r;
    logic [9:0] x_r;
    logic [9:0] y_r;
    logic       video_on_r;
    logic       hsync_r;
    logic       vsync_r;
    logic       frame_start_r;

    logic       tick_s;
    logic [3:0] div_nxt_s;
    logic [9:0] x_nxt_s;
    logic [9:0] y_nxt_s;
    logic       frame_wrap_s;

    // Next-state counters; decode below uses these so outputs carry no skew vs x/y.
    always_comb begin
        tick_s       = (div_r == DIV_MAX);
        div_nxt_s    = div_r + 4'd1;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        frame_wrap_s = 1'b0;
        if (tick_s) begin
            div_nxt_s = 4'd0;
            if (x_r == X_MAX) begin
                x_nxt_s = 10'd0;
                if (y_r == Y_MAX) begin
                    y_nxt_s      = 10'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    y_nxt_s = y_r + 10'd1;
                end
            end else begin
                x_nxt_s = x_r + 10'd1;
            end
        end else begin
            div_nxt_s = div_r + 4'd1;
        end
    end

    // State and registered output decode; reset state equals decode of (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r         <= 4'd0;
            p_tick_r      <= 1'b0;
            x_r           <= 10'd0;
            y_r           <= 10'd0;
            video_on_r    <= 1'b1;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_nxt_s;
            p_tick_r      <= tick_s;
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            video_on_r    <= (x_nxt_s < X_VIS) && (y_nxt_s < Y_VIS);
            hsync_r       <= !((x_nxt_s >= HS_START) && (x_nxt_s <= HS_END));
            vsync_r       <= !((y_nxt_s >= VS_START) && (y_nxt_s <= VS_END));
            frame_start_r <= frame_wrap_s;
        end
    end

    assign p_tick      = p_tick_r;
    assign x           = x_r;
    assign y           = y_r;
    assign video_on    = video_on_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four instances with different timing parameters,
// compared every clock against a raster-position model driven by random resets.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       frame_start;
    } vid_t;

    localparam int N = 4;
    localparam int P_DIV [N] = '{4, 1, 4, 3};
    localparam int P_HV  [N] = '{16, 4, 640, 16};
    localparam int P_HFP [N] = '{2, 1, 16, 2};
    localparam int P_HS  [N] = '{4, 2, 96, 4};
    localparam int P_HBP [N] = '{3, 1, 48, 3};
    localparam int P_VV  [N] = '{12, 3, 480, 12};
    localparam int P_VFP [N] = '{2, 1, 10, 2};
    localparam int P_VS  [N] = '{2, 1, 2, 2};
    localparam int P_VBP [N] = '{3, 1, 33, 3};

    logic       clk = 1'b0;
    logic       reset;
    logic       pt [N];
    logic [9:0] xx [N];
    logic [9:0] yy [N];
    logic       vo [N];
    logic       hs [N];
    logic       vs [N];
    logic       fs [N];

    int  cyc = 0;
    logic valid = 1'b0;
    int  n_checks = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_sync_gen #(
            .CLK_DIV(P_DIV[g]), .H_VIS(P_HV[g]), .H_FP(P_HFP[g]), .H_SYNC(P_HS[g]),
            .H_BP(P_HBP[g]), .V_VIS(P_VV[g]), .V_FP(P_VFP[g]), .V_SYNC(P_VS[g]),
            .V_BP(P_VBP[g])
        ) u_dut (
            .clk(clk), .reset(reset), .p_tick(pt[g]), .x(xx[g]), .y(yy[g]),
            .video_on(vo[g]), .hsync(hs[g]), .vsync(vs[g]), .frame_start(fs[g])
        );
    end

    // Outputs after c clock edges since the last reset edge (c==0: in reset).
    function automatic vid_t model(int k, int c);
        vid_t e;
        int ht, vt, n, pos, hs0, vs0;
        ht  = P_HV[k] + P_HFP[k] + P_HS[k] + P_HBP[k];
        vt  = P_VV[k] + P_VFP[k] + P_VS[k] + P_VBP[k];
        n   = c / P_DIV[k];
        pos = n % (ht * vt);
        hs0 = P_HV[k] + P_HFP[k];
        vs0 = P_VV[k] + P_VFP[k];
        e.x           = 10'(pos % ht);
        e.y           = 10'(pos / ht);
        e.p_tick      = (c > 0) && (c % P_DIV[k] == 0);
        e.frame_start = e.p_tick && (pos == 0);
        e.video_on    = (int'(e.x) < P_HV[k]) && (int'(e.y) < P_VV[k]);
        e.hsync       = !((int'(e.x) >= hs0) && (int'(e.x) < hs0 + P_HS[k]));
        e.vsync       = !((int'(e.y) >= vs0) && (int'(e.y) < vs0 + P_VS[k]));
        return e;
    endfunction

    function automatic vid_t actual(int k);
        vid_t a;
        a.p_tick = pt[k]; a.x = xx[k]; a.y = yy[k]; a.video_on = vo[k];
        a.hsync = hs[k]; a.vsync = vs[k]; a.frame_start = fs[k];
        return a;
    endfunction

    task automatic check(string name, int k, vid_t a, vid_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s dut%0d c=%0d actual pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b required pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b",
                     name, k, cyc, a.p_tick, a.x, a.y, a.video_on, a.hsync, a.vsync, a.frame_start,
                     e.p_tick, e.x, e.y, e.video_on, e.hsync, e.vsync, e.frame_start);
        end
    endtask

    // Hand-computed literal expectation for a single instance at this cycle.
    function automatic vid_t lit(logic p, int x0, int y0, logic v, logic h, logic s, logic f);
        vid_t e;
        e.p_tick = p; e.x = 10'(x0); e.y = 10'(y0); e.video_on = v;
        e.hsync = h; e.vsync = s; e.frame_start = f;
        return e;
    endfunction

    // Edge counter since the last reset edge.
    always @(posedge clk) begin
        if (reset) begin
            cyc   <= 0;
            valid <= 1'b1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    // Compare all instances on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            for (int k = 0; k < N; k++) check("model", k, actual(k), model(k, cyc));
            case (cyc)
                0:    check("reset_vals", 2, actual(2), lit(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
                3:    check("pre_tick",   0, actual(0), lit(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
                4:    check("first_tick", 0, actual(0), lit(1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0));
                8:    check("second_tick",0, actual(0), lit(1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0));
                37:   check("tiny_sync",  1, actual(1), lit(1'b1, 5, 4, 1'b0, 1'b0, 1'b0, 1'b0));
                47:   check("tiny_last",  1, actual(1), lit(1'b1, 7, 5, 1'b0, 1'b1, 1'b1, 1'b0));
                48:   check("tiny_frame", 1, actual(1), lit(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1));
                1900: check("a_frame",    0, actual(0), lit(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1));
                2560: check("von_fall",   2, actual(2), lit(1'b1, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0));
                2623: check("pre_hsync",  2, actual(2), lit(1'b0, 655, 0, 1'b0, 1'b1, 1'b1, 1'b0));
                2624: check("hsync_fall", 2, actual(2), lit(1'b1, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0));
                3007: check("hsync_low",  2, actual(2), lit(1'b0, 751, 0, 1'b0, 1'b0, 1'b1, 1'b0));
                3008: check("hsync_rise", 2, actual(2), lit(1'b1, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0));
                3200: check("line_wrap",  2, actual(2), lit(1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0));
                default: ;
            endcase
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (7000) @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(1, 450)) @(negedge clk);
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (2500) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
